uart_ram_tx: RTL
================

UART_RAM_TX -- requirements
Module: uart_ram_tx

Interface
REQ-001 SHALL have parameter DELAY, default 234, clocks per UART bit (115200 baud at 27 MHz).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  level sampled each edge; starts a dump when idle.
REQ-005 SHALL have port wordCount  input  8  number of 16-bit words to send; latched when start is accepted.
REQ-006 SHALL have port addrRd  output  8  memory read address (registered).
REQ-007 SHALL have port dataIn  input  16  memory read data, valid one clock after addrRd changes.
REQ-008 SHALL have port tx  output  1  UART serial line (registered), idle high.
REQ-009 SHALL have port busy  output  1  high from accept of start until the dump completes.
REQ-010 SHALL have port done  output  1  one-cycle pulse at dump completion.

Function
REQ-011 SHALL use states IDLE, FETCH, LOAD, START_BIT, DATA_BITS, STOP_BIT (plus CHK_LOAD when the Configuration feature is compiled in).
REQ-012 SHALL accept start only in IDLE: set addrRd=0, latch wordCount, set busy=1, go to FETCH.
REQ-013 SHALL ignore start while busy=1.
REQ-014 SHALL treat wordCount=0 specially: busy never rises; done pulses on the edge after start is sampled; tx stays high.
REQ-015 SHALL spend exactly 1 clock in FETCH; LOAD latches dataIn into a 16-bit shift holding register.
REQ-016 SHALL drive tx low 2 clocks after the edge that accepted start.
REQ-017 SHALL send each word as low byte dataIn[7:0], then high byte dataIn[15:8].
REQ-018 SHALL frame each byte as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly DELAY clocks.
REQ-019 SHALL time each bit with a counter 0..DELAY-1 that is reloaded at every bit boundary (no cumulative drift).
REQ-020 SHALL start the high byte's start bit immediately after the low byte's stop bit, with no gap.
REQ-021 SHALL, after a high byte's stop bit, increment addrRd and return to FETCH if words remain; tx holds high during the 2-cycle FETCH/LOAD gap.
REQ-022 SHALL, after the final stop bit, return to IDLE, drop busy and pulse done, all on the same edge.
REQ-023 SHALL take 20*DELAY+2 clocks from start accept to done for a single word (without the Configuration feature).
REQ-024 SHALL send addresses 0..wordCount-1 in increasing order; addrRd never exceeds wordCount-1.

Reset
REQ-025 SHALL, with reset high at an edge, set tx=1, busy=0, done=0, addrRd=0, state=IDLE and clear the bit counter and checksum.
REQ-026 SHALL, on reset mid-frame, abort the frame with tx high on the next edge; no done pulse is produced.
REQ-027 SHALL give reset priority over start when both are high on the same edge.

Configuration
REQ-028 SHALL, when macro UART_TX_CHECKSUM_EN is defined, append one extra byte after the last word: XOR of all data bytes sent, framed per REQ-018 with no gap after the last stop bit; done follows that byte's stop bit.
REQ-029 SHALL, when UART_TX_CHECKSUM_EN is undefined, contain no checksum logic and end the dump after the last word; wordCount=0 sends nothing in both builds.

Verification
REQ-030 SHALL cover reset for 10 clocks -> tx=1, busy=0, done=0, addrRd=0.
REQ-031 SHALL cover mem[0]=0x130B, mem[1]=0x0E00, wordCount=2, start pulse, DELAY=234 -> decoded bytes 0x0B, 0x13, 0x00, 0x0E; addrRd 0 then 1; exactly one done pulse.
REQ-032 SHALL cover start re-asserted during the second byte -> byte stream and timing identical to REQ-031.
REQ-033 SHALL cover reset asserted at data bit 4 of the first byte -> tx=1 next edge, busy=0, no done; a new start restarts from addrRd=0 with byte 0x0B.
REQ-034 SHALL cover wordCount=0 with start -> done pulse 1 clock later, busy stays 0, tx never low.
REQ-035 SHALL cover the REQ-031 stimulus with UART_TX_CHECKSUM_EN defined -> fifth byte 0x16, then done.

Source files
------------

// File: rtl/uart_ram_tx.sv
// Sends wordCount 16-bit words read from a synchronous RAM over a UART line, low byte first.
// Optional trailing XOR checksum byte when UART_TX_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module uart_ram_tx #(
    parameter int unsigned DELAY = 234
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  wordCount,
    output logic [7:0]  addrRd,
    input  logic [15:0] dataIn,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DELAY - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START_BIT,
        DATA_BITS,
        STOP_BIT
`ifdef UART_TX_CHECKSUM_EN
        , CHK_LOAD
`endif
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bitidx, bit_n;
    logic [15:0]   hold, hold_n;
    logic          hi, hi_n;
    logic [7:0]    wc, wc_n;
    logic [7:0]    addr_n;
    logic          tx_n, busy_n, done_n;
    logic          tick;
`ifdef UART_TX_CHECKSUM_EN
    logic [7:0]    cksum, ck_n;
    logic          chk, chk_n;
`endif

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            bitidx <= '0;
            hold   <= '0;
            hi     <= 1'b0;
            wc     <= '0;
            addrRd <= '0;
            tx     <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
            cksum  <= '0;
            chk    <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bitidx <= bit_n;
            hold   <= hold_n;
            hi     <= hi_n;
            wc     <= wc_n;
            addrRd <= addr_n;
            tx     <= tx_n;
            busy   <= busy_n;
            done   <= done_n;
`ifdef UART_TX_CHECKSUM_EN
            cksum  <= ck_n;
            chk    <= chk_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bitidx;
        hold_n  = hold;
        hi_n    = hi;
        wc_n    = wc;
        addr_n  = addrRd;
        tx_n    = tx;
        busy_n  = busy;
        done_n  = 1'b0;
`ifdef UART_TX_CHECKSUM_EN
        ck_n    = cksum;
        chk_n   = chk;
`endif
        case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (start) begin
                    addr_n = '0;
                    wc_n   = wordCount;
                    if (wordCount == 8'd0) begin
                        done_n = 1'b1;
                    end else begin
                        busy_n  = 1'b1;
                        hi_n    = 1'b0;
                        state_n = FETCH;
`ifdef UART_TX_CHECKSUM_EN
                        ck_n    = '0;
                        chk_n   = 1'b0;
`endif
                    end
                end
            end
            FETCH: state_n = LOAD;
            LOAD: begin
                hold_n  = dataIn;
                tx_n    = 1'b0;
                cnt_n   = '0;
                state_n = START_BIT;
`ifdef UART_TX_CHECKSUM_EN
                ck_n    = cksum ^ dataIn[7:0] ^ dataIn[15:8];
`endif
            end
`ifdef UART_TX_CHECKSUM_EN
            START_BIT, CHK_LOAD: begin
`else
            START_BIT: begin
`endif
                if (tick) begin
                    cnt_n   = '0;
                    tx_n    = hold[0];
                    hold_n  = {1'b0, hold[15:1]};
                    bit_n   = '0;
                    state_n = DATA_BITS;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA_BITS: begin
                if (tick) begin
                    cnt_n = '0;
                    if (bitidx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP_BIT;
                    end else begin
                        tx_n   = hold[0];
                        hold_n = {1'b0, hold[15:1]};
                        bit_n  = bitidx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP_BIT: begin
                if (tick) begin
                    cnt_n = '0;
                    // after the low byte, the high byte already sits in hold[7:0]
                    if (!hi) begin
                        hi_n    = 1'b1;
                        tx_n    = 1'b0;
                        state_n = START_BIT;
                    end else if (addrRd != wc - 8'd1) begin
                        hi_n    = 1'b0;
                        addr_n  = addrRd + 8'd1;
                        state_n = FETCH;
                    end else begin
`ifdef UART_TX_CHECKSUM_EN
                        if (!chk) begin
                            chk_n   = 1'b1;
                            hold_n  = {8'h00, cksum};
                            tx_n    = 1'b0;
                            state_n = CHK_LOAD;
                        end else begin
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end
`else
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
`endif
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
